// File: rtl/nlfsr_step_sequencer.sv
// Clocked sequencer for the 4-bit XOR/NOR nonlinear feedback network (LOAD seed / RUN N steps).
// Latency: LOAD visible 1 cycle after the start edge; RUN N steps finishes N cycles after busy rises.
// Backpressure: none. Start edges during RUN are dropped, not queued. NLFSR_STUCK_DETECT_EN enables the fixed-point abort.
module nlfsr_step_sequencer (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  logic       clk;
  logic       rst_n;
  logic       start_in;
  logic       mode_in;
  logic [3:0] arg_in;

  assign clk      = io_in[0];
  assign rst_n    = io_in[1];
  assign start_in = io_in[2];
  assign mode_in  = io_in[3];
  assign arg_in   = io_in[7:4];

  state_e     state_q, state_d;
  logic [3:0] q_q,     q_d;
  logic [4:0] cnt_q,   cnt_d;
  logic       busy_q,  busy_d;
  logic       done_q,  done_d;
  logic       start_q, start_d;
  logic       start_edge;
  logic [3:0] q_next;
  logic       fixed_pt;
`ifdef NLFSR_STUCK_DETECT_EN
  logic       stuck_q, stuck_d;
`endif

  // One network step; n3 and n2 are reused inside the same step for n1 and n0.
  function automatic logic [3:0] step_f(input logic [3:0] s);
    logic n3, n2, n1, n0;
    n3 = s[0] ^ ~(s[3] | s[2]);
    n2 = s[3] ^ ~(s[2] | s[1]);
    n1 = s[2] ^ ~(s[1] | n3);
    n0 = s[1] ^ ~(n3 | n2);
    return {n3, n2, n1, n0};
  endfunction

  assign start_edge = start_in & ~start_q;
  assign q_next     = step_f(q_q);

`ifdef NLFSR_STUCK_DETECT_EN
  assign fixed_pt = (q_next == q_q);
`else
  assign fixed_pt = 1'b0;
`endif

  // Next-state and datapath: accept commands in IDLE/DONE, step the network in RUN.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    start_d = start_in;
`ifdef NLFSR_STUCK_DETECT_EN
    stuck_d = stuck_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_edge) begin
`ifdef NLFSR_STUCK_DETECT_EN
          stuck_d = 1'b0;
`endif
          if (!mode_in) begin
            q_d     = arg_in;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            cnt_d   = (arg_in == 4'd0) ? 5'd16 : {1'b0, arg_in};
            busy_d  = 1'b1;
            done_d  = 1'b0;
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (fixed_pt) begin
          // Network cannot move any further: stop early, leave q as is.
          busy_d  = 1'b0;
          done_d  = 1'b1;
          cnt_d   = 5'd0;
          state_d = ST_DONE;
`ifdef NLFSR_STUCK_DETECT_EN
          stuck_d = 1'b1;
`endif
        end else begin
          q_d   = q_next;
          cnt_d = cnt_q - 5'd1;
          if (cnt_q == 5'd1) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      q_q     <= 4'd0;
      cnt_q   <= 5'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      start_q <= 1'b0;
`ifdef NLFSR_STUCK_DETECT_EN
      stuck_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      start_q <= start_d;
`ifdef NLFSR_STUCK_DETECT_EN
      stuck_q <= stuck_d;
`endif
    end
  end

`ifdef NLFSR_STUCK_DETECT_EN
  assign io_out = {^q_q, stuck_q, done_q, busy_q, q_q};
`else
  assign io_out = {^q_q, 1'b0, done_q, busy_q, q_q};
`endif

endmodule

// File: tb/tb_nlfsr_step_sequencer.sv
// Randomized scoreboard bench for nlfsr_step_sequencer.
// The driver pushes one expected io_out per rising edge; the monitor compares on the falling edge.
// The reference model expands each command into its whole expected output trace.
module tb_nlfsr_step_sequencer;

`ifdef NLFSR_STUCK_DETECT_EN
  localparam bit STUCK_EN = 1'b1;
`else
  localparam bit STUCK_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       mode;
  logic [3:0] arg;
  logic [7:0] io_in;
  logic [7:0] io_out;

  assign io_in = {arg, mode, start, rst_n, clk};

  nlfsr_step_sequencer dut (
    .io_in (io_in),
    .io_out(io_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] sb[$];
  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model state: what the outputs should read after the most recent edge.
  logic [3:0] cq;
  logic       cbusy, cdone, cstuck;
  logic       prev_start;

  function automatic logic [3:0] f(input logic [3:0] s);
    logic n3, n2, n1, n0;
    n3 = s[0] ^ ~(s[3] | s[2]);
    n2 = s[3] ^ ~(s[2] | s[1]);
    n1 = s[2] ^ ~(s[1] | n3);
    n0 = s[1] ^ ~(n3 | n2);
    return {n3, n2, n1, n0};
  endfunction

  function automatic logic [7:0] exp_out();
    return {^cq, cstuck, cdone, cbusy, cq};
  endfunction

  // Monitor: every falling edge with a pending expectation is one comparison.
  always @(negedge clk) begin
    cyc++;
    if (sb.size() > 0) begin
      logic [7:0] e;
      e = sb.pop_front();
      checks++;
      if (io_out !== e) begin
        errors++;
        $display("FAIL io_out cycle %0d: got %02h expected %02h", cyc, io_out, e);
      end
    end
  end

  task automatic step(input logic [7:0] e);
    @(posedge clk);
    sb.push_back(e);
    prev_start = rst_n ? start : 1'b0;
    #1;
  endtask

  task automatic idle(input int n);
    start = 1'b0;
    repeat (n) step(exp_out());
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    step(8'h00);
    cq = 4'd0; cbusy = 1'b0; cdone = 1'b0; cstuck = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic do_load(input logic [3:0] v);
    if (prev_start) idle(1);
    start = 1'b1; mode = 1'b0; arg = v;
    cq = v; cdone = 1'b1; cstuck = 1'b0;
    step(exp_out());
  endtask

  // RUN a; stops generating after max_steps steps (caller then resets).
  task automatic do_run(input logic [3:0] a, input bit toggle, input int max_steps);
    int n;
    logic [3:0] nq;
    if (prev_start) idle(1);
    n = (a == 4'd0) ? 16 : int'(a);
    start = 1'b1; mode = 1'b1; arg = a;
    cbusy = 1'b1; cdone = 1'b0; cstuck = 1'b0;
    step(exp_out());
    for (int i = 1; i <= n; i++) begin
      if (i > max_steps) return;
      if (toggle) begin
        start = 1'($urandom_range(0, 1));
        mode  = 1'($urandom_range(0, 1));
        arg   = 4'($urandom);
      end else begin
        start = 1'b0;
      end
      nq = f(cq);
      if (STUCK_EN && nq == cq) begin
        cbusy = 1'b0; cdone = 1'b1; cstuck = 1'b1;
        step(exp_out());
        return;
      end
      cq = nq;
      if (i == n) begin
        cbusy = 1'b0; cdone = 1'b1;
      end
      step(exp_out());
    end
  endtask

  initial begin
    cq = 4'd0; cbusy = 1'b0; cdone = 1'b0; cstuck = 1'b0; prev_start = 1'b0;
    // Reset with start held high; the held level counts as an edge after release.
    rst_n = 1'b0; start = 1'b1; mode = 1'b0; arg = 4'b1010;
    step(8'h00);
    step(8'h00);
    rst_n = 1'b1;
    do_load(4'b1010);           // expect 0x2A
    idle(2);

    // RUN 3 from 0000: 1100, 0100, 0001 then done with parity 1.
    do_load(4'b0000);
    do_run(4'd3, 1'b0, 99);
    idle(2);

    // RUN 0 means 16 steps.
    do_load(4'b0000);
    do_run(4'd0, 1'b0, 99);
    idle(1);

    // 1111 is a fixed point of the network.
    do_load(4'b1111);
    do_run(4'd5, 1'b0, 99);
    idle(2);

    // Start toggling and arg/mode noise during RUN must be ignored.
    do_load(4'b0110);
    do_run(4'd10, 1'b1, 99);
    idle(1);

    // Reset two steps into RUN 8, then a normal LOAD.
    do_load(4'b0011);
    do_run(4'd8, 1'b0, 2);
    do_reset();
    do_load(4'b1001);
    idle(2);

    // Randomized command mix.
    repeat (40) begin
      case ($urandom_range(0, 3))
        0: do_load(4'($urandom));
        1, 2: do_run(4'($urandom), 1'($urandom_range(0, 1)), 99);
        default: begin
          do_run(4'($urandom), 1'b0, int'($urandom_range(0, 3)));
          do_reset();
        end
      endcase
      idle(int'($urandom_range(0, 2)));
    end

    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nlfsr_step_sequencer.md
# nlfsr_step_sequencer

- Clocked sequencer for the 4-bit XOR/NOR nonlinear feedback network.
- Holds the network state in a 4-bit register, so there is no combinational loop.
- Accepts two commands from the I/O pins: load a seed, or run N steps. Reports busy, done and stuck flags.
- Occupies one standard 8-in/8-out user-module slot on the shared chip.

## Interface
- Parameters: none.
- `io_in` input 8 (bit fields below):
  - `io_in[0]` = clk: the single clock; all state changes on its rising edge.
  - `io_in[1]` = rst_n: synchronous, active-low reset.
  - `io_in[2]` = start: a command is issued on its rising edge.
  - `io_in[3]` = mode: 0 = LOAD, 1 = RUN.
  - `io_in[7:4]` = arg: the seed (LOAD) or the step count (RUN; 0 means 16).
- `io_out` output 8:
  - `[3:0]` q: state register.
  - `[4]` busy.
  - `[5]` done.
  - `[6]` stuck.
  - `[7]` parity, equal to ^q.

## Operation
- Step function f(q) → n, written with q3..q0:
  - n3 = q0 ^ ~(q3|q2)
  - n2 = q3 ^ ~(q2|q1)
  - n1 = q2 ^ ~(q1|n3)
  - n0 = q1 ^ ~(n3|n2)
- Start edge: start_q is a register that samples `io_in[2]` every cycle. edge = io_in[2] & ~start_q.
- FSM states: IDLE, RUN, DONE. Reset enters IDLE.
- IDLE or DONE, on edge with mode=0 (LOAD):
  - q ← arg, done ← 1, stuck ← 0, next state DONE.
- IDLE or DONE, on edge with mode=1 (RUN):
  - cnt ← arg (0 is loaded as 16), busy ← 1, done ← 0, stuck ← 0, next state RUN.
- RUN, each cycle:
  - q ← f(q), cnt ← cnt−1.
  - When cnt==1 on that edge: busy ← 0, done ← 1, next state DONE.
- RUN, fixed-point abort:
  - If f(q)==q on a step edge: busy ← 0, done ← 1, stuck ← 1, cnt ← 0, next state DONE. q is unchanged.
  - This has priority over the normal cnt==1 completion.
- Start edges while in RUN are ignored and are not queued. mode and arg are don't-care during RUN.
- Counter: 5 bits, so the value 16 is representable. No wrap; it never decrements below 1 in RUN.
- DONE stays set until the next accepted command.

## Timing
- Reset: when rst_n is low at a rising edge, then after that edge:
  - q=0000, busy=0, done=0, stuck=0, io_out[7]=0.
  - cnt=0, start_q=0, state IDLE.
- Reset mid-RUN aborts immediately with the same values.
- After reset, start_q=0. A start already held high is therefore seen as an edge on the first cycle with rst_n=1.
- Edge sampled at rising edge k:
  - LOAD: q and done are valid after edge k, so latency is 1 cycle.
  - RUN N: busy is valid after k. Steps occur at edges k+1 … k+N. After edge k+N: busy=0, done=1, q = f^N(seed).
- busy and done are never 1 together.
- All outputs come directly from registers, or from one XOR of q; no input reaches an output combinationally.

## Configuration
- Macro `NLFSR_STUCK_DETECT_EN`:
  - Defined: the fixed-point abort is active and `io_out[6]` reports stuck.
  - Undefined: there is no comparator, `io_out[6]` is tied to 0, and RUN always executes the full N steps, even at a fixed point.

## Test plan
- Reset with start held high, then release with mode=0, arg=1010 → one cycle later q=1010, done=1, parity=0.
- LOAD 0000, then RUN arg=3 → busy high for exactly 3 cycles; q goes 1100, 0100, 0001; then done=1, io_out=0b1_0_1_0_0001.
- RUN arg=0 from seed 0000 → busy for exactly 16 cycles, then done=1.
- LOAD 1111, then RUN arg=5 → with EN: after the first step edge, stuck=1, done=1, busy=0, q=1111. Without EN: busy for 5 cycles, stuck=0.
- Toggle start repeatedly during RUN → no effect on cnt or q; completion occurs at the original cycle.
- Assert rst_n=0 two cycles into RUN 8 → next cycle io_out=0x00, state IDLE; a new LOAD is then accepted normally.
